// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: bitslip search that aligns an ISERDES frame-clock lane onto a target word.
// Build option FRAME_ALIGN_RELOCK_EN: after loss of lock, restart the search without waiting for start.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start
// S_SETTLE | settle timer counting down after start or a bitslip
// S_CHECK  | counting consecutive frame_word == TARGET matches
// S_SLIP   | one-cycle bitslip pulse, slip_count advances on exit
// S_LOCKED | aligned, every word still compared against TARGET
// S_FAIL   | slip budget exhausted, waiting for start
module frame_align_ctrl #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TARGET      = WIDTH'(8'hF0),
  parameter int               SETTLE      = 16,
  parameter int               LOCK_CHECKS = 4,
  parameter int               MAX_SLIPS   = 16
) (
  input  logic             sample_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] frame_word,
  output logic             bitslip,
  output logic             aligned,
  output logic             failed,
  output logic [4:0]       slip_count,
  output logic             lost_lock
);

  localparam logic [7:0] SETTLE_C    = 8'(SETTLE);
  localparam logic [3:0] LOCK_LAST_C = 4'(LOCK_CHECKS - 1);
  localparam logic [4:0] MAX_SLIPS_C = 5'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t     state;
  logic [7:0] settle_cnt;
  logic [3:0] match_cnt;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      slip_count <= '0;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      failed     <= 1'b0;
      lost_lock  <= 1'b0;
    end else if (start) begin
      state      <= S_SETTLE;
      settle_cnt <= SETTLE_C;
      match_cnt  <= '0;
      slip_count <= '0;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      failed     <= 1'b0;
      lost_lock  <= 1'b0;
    end else begin
      // bitslip is only ever set on the transition into S_SLIP, so it cannot repeat
      bitslip <= 1'b0;
      case (state)
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt <= 8'd1) begin
            settle_cnt <= '0;
            match_cnt  <= '0;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (frame_word == TARGET) begin
            match_cnt <= match_cnt + 4'd1;
            if (match_cnt >= LOCK_LAST_C) begin
              aligned <= 1'b1;
              state   <= S_LOCKED;
            end
          end else begin
            match_cnt <= '0;
            if (slip_count < MAX_SLIPS_C) begin
              bitslip <= 1'b1;
              state   <= S_SLIP;
            end else begin
              failed <= 1'b1;
              state  <= S_FAIL;
            end
          end
        end
        S_SLIP: begin
          if (slip_count < MAX_SLIPS_C) begin
            slip_count <= slip_count + 5'd1;
          end
          settle_cnt <= SETTLE_C;
          state      <= S_SETTLE;
        end
        S_LOCKED: begin
          if (frame_word != TARGET) begin
            lost_lock <= 1'b1;
            aligned   <= 1'b0;
`ifdef FRAME_ALIGN_RELOCK_EN
            slip_count <= '0;
            match_cnt  <= '0;
            settle_cnt <= SETTLE_C;
            state      <= S_SETTLE;
`else
            state <= S_IDLE;
`endif
          end
        end
        S_IDLE, S_FAIL: begin
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Scoreboard bench for frame_align_ctrl: a lane model answers bitslip, a reference model
// predicts every bitslip pulse, lock and give-up event with its cycle and slip_count.
`timescale 1ns/1ps
module tb_frame_align_ctrl;
  localparam int         WIDTH       = 8;
  localparam logic [7:0] TARGET      = 8'hF0;
  localparam int         SETTLE      = 4;
  localparam int         LOCK_CHECKS = 4;
  localparam int         MAX_SLIPS   = 15;

  logic       sample_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] frame_word;
  logic       bitslip, aligned, failed, lost_lock;
  logic [4:0] slip_count;

  always #5 sample_clk = ~sample_clk;

  frame_align_ctrl #(
    .WIDTH(WIDTH), .TARGET(TARGET), .SETTLE(SETTLE),
    .LOCK_CHECKS(LOCK_CHECKS), .MAX_SLIPS(MAX_SLIPS)
  ) dut (
    .sample_clk(sample_clk), .reset(reset), .start(start), .frame_word(frame_word),
    .bitslip(bitslip), .aligned(aligned), .failed(failed),
    .slip_count(slip_count), .lost_lock(lost_lock)
  );

  function automatic logic [7:0] rotl8(logic [7:0] w, int k);
    int s;
    s = k & 7;
    return (w << s) | (w >> (8 - s));
  endfunction

  function automatic logic [7:0] rotr8(logic [7:0] w, int k);
    return rotl8(w, 8 - (k & 7));
  endfunction

  // Lane offset is a left rotation of TARGET; every bitslip takes one bit of it back out.
  int         lane_base = 0;
  int         slips_applied = 0;
  int         rot_delay = 0;
  bit         stuck = 1'b0;
  logic [7:0] stuck_word = 8'h00;

  assign frame_word = stuck ? stuck_word : rotl8(TARGET, lane_base - slips_applied);

  always @(negedge sample_clk) begin
    if (rot_delay == 1) slips_applied <= slips_applied + 1;
    if (bitslip) rot_delay <= 2;
    else if (rot_delay > 0) rot_delay <= rot_delay - 1;
  end

  int cyc = 0;
  always @(posedge sample_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;
  ev_t sb[$];

  function automatic string kname(int k);
    case (k)
      0:       return "slip";
      1:       return "lock";
      default: return "give_up";
    endcase
  endfunction

  // Smallest number of one-bit slips that turns w into TARGET, -1 if none within budget.
  function automatic int slips_to_align(logic [7:0] w);
    for (int j = 0; j <= MAX_SLIPS; j++) if (rotr8(w, j) == TARGET) return j;
    return -1;
  endfunction

  // Search starting at edge t0: pulse i after SETTLE+1+(SETTLE+2)*i, lock after
  // SETTLE+LOCK_CHECKS plus SETTLE+2 per slip, give-up after the slip budget.
  task automatic expect_run(int t0, int nslip);
    int n;
    n = (nslip < 0) ? MAX_SLIPS : nslip;
    for (int i = 0; i < n; i++) sb.push_back('{0, t0 + SETTLE + 1 + (SETTLE + 2) * i, i});
    if (nslip < 0) sb.push_back('{2, t0 + SETTLE + 1 + (SETTLE + 2) * MAX_SLIPS, MAX_SLIPS});
    else sb.push_back('{1, t0 + SETTLE + LOCK_CHECKS + (SETTLE + 2) * n, n});
  endtask

  task automatic observe(int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: got event at cycle %0d, required none", kname(kind), cyc);
    end else begin
      e = sb.pop_front();
      chk({"kind_", kname(e.kind)}, kind, e.kind);
      chk({"cycle_", kname(e.kind)}, cyc, e.cyc);
      chk({"slip_count_", kname(e.kind)}, int'(slip_count), e.cnt);
    end
  endtask

  logic prev_bitslip = 1'b0, prev_aligned = 1'b0, prev_failed = 1'b0;

  initial begin
    forever begin
      @(negedge sample_clk);
      if (bitslip) begin
        chk("bitslip_back_to_back", int'(prev_bitslip), 0);
        observe(0);
      end
      if (aligned && !prev_aligned) observe(1);
      if (failed && !prev_failed) observe(2);
      prev_bitslip = bitslip;
      prev_aligned = aligned;
      prev_failed  = failed;
    end
  end

  task automatic pulse_start(output int t0);
    @(negedge sample_clk);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge sample_clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge sample_clk);
    if (sb.size() != 0) begin
      chk("event_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_final(string tag, int n);
    @(negedge sample_clk);
    chk({tag, "_aligned"}, int'(aligned), (n >= 0) ? 1 : 0);
    chk({tag, "_failed"}, int'(failed), (n >= 0) ? 0 : 1);
    chk({tag, "_slip_count"}, int'(slip_count), (n >= 0) ? n : MAX_SLIPS);
  endtask

  task automatic run_lane(string tag, int offset, bit use_stuck, logic [7:0] sw);
    int t0, n;
    @(negedge sample_clk);
    stuck      = use_stuck;
    stuck_word = sw;
    lane_base  = offset + slips_applied;
    n = use_stuck ? ((sw == TARGET) ? 0 : -1) : slips_to_align(rotl8(TARGET, offset));
    pulse_start(t0);
    expect_run(t0, n);
    wait_drain(200);
    check_final(tag, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, g, w, r;
    bit seen;
    repeat (3) @(negedge sample_clk);
    chk("rst_bitslip", int'(bitslip), 0);
    chk("rst_aligned", int'(aligned), 0);
    chk("rst_failed", int'(failed), 0);
    chk("rst_slip_count", int'(slip_count), 0);
    chk("rst_lost_lock", int'(lost_lock), 0);
    reset = 1'b0;
    repeat (2) @(negedge sample_clk);

    run_lane("offset0", 0, 1'b0, 8'h00);
    run_lane("offset3", 3, 1'b0, 8'h00);
    run_lane("stuck_aa", 0, 1'b1, 8'hAA);
    repeat (20) @(negedge sample_clk);
    chk("stuck_bitslip_quiet", int'(bitslip), 0);
    chk("stuck_failed_held", int'(failed), 1);

    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 3);
      w = $urandom_range(0, 255);
      if (r == 0) run_lane("rand_stuck", 0, 1'b1, 8'(w));
      else run_lane("rand_offset", $urandom_range(0, 7), 1'b0, 8'h00);
      repeat (3) @(negedge sample_clk);
    end

    // loss of lock
    run_lane("pre_loss", 0, 1'b0, 8'h00);
    @(negedge sample_clk);
    g = cyc + 1;
`ifdef FRAME_ALIGN_RELOCK_EN
    stuck     = 1'b0;
    lane_base = 1 + slips_applied;
    expect_run(g, slips_to_align(8'hE1));
    @(negedge sample_clk);
    chk("loss_aligned_drop", int'(aligned), 0);
    chk("loss_lost_lock", int'(lost_lock), 1);
    wait_drain(200);
    check_final("relock", 1);
    chk("relock_lost_lock_sticky", int'(lost_lock), 1);
`else
    stuck      = 1'b1;
    stuck_word = 8'hE1;
    @(negedge sample_clk);
    stuck = 1'b0;
    chk("loss_aligned_drop", int'(aligned), 0);
    chk("loss_lost_lock", int'(lost_lock), 1);
    repeat (20) @(negedge sample_clk);
    chk("loss_idle_aligned", int'(aligned), 0);
    chk("loss_idle_lost_lock", int'(lost_lock), 1);
`endif
    run_lane("after_loss", 0, 1'b0, 8'h00);
    chk("start_clears_lost_lock", int'(lost_lock), 0);

    // reset landing on the SLIP cycle
    @(negedge sample_clk);
    stuck     = 1'b0;
    lane_base = 3 + slips_applied;
    pulse_start(t0);
    expect_run(t0, 3);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge sample_clk);
      if (bitslip) seen = 1'b1;
    end
    chk("slip_seen_before_reset", int'(seen), 1);
    reset = 1'b1;
    @(posedge sample_clk);
    #1 sb.delete();
    @(negedge sample_clk);
    reset = 1'b0;
    chk("slip_rst_bitslip", int'(bitslip), 0);
    chk("slip_rst_aligned", int'(aligned), 0);
    chk("slip_rst_failed", int'(failed), 0);
    chk("slip_rst_slip_count", int'(slip_count), 0);
    chk("slip_rst_lost_lock", int'(lost_lock), 0);
    repeat (20) @(negedge sample_clk);
    chk("slip_rst_idle_aligned", int'(aligned), 0);
    chk("slip_rst_idle_slip_count", int'(slip_count), 0);

    // restart while CHECK holds two matches
    @(negedge sample_clk);
    stuck     = 1'b0;
    lane_base = slips_applied;
    pulse_start(t0);
    expect_run(t0, 0);
    while (cyc < t0 + SETTLE + 2) @(negedge sample_clk);
    start = 1'b1;
    sb.delete();
    g = cyc + 1;
    @(negedge sample_clk);
    start = 1'b0;
    expect_run(g, 0);
    wait_drain(100);
    check_final("restart", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
